// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types, constants and helpers (PARITY state exists only with UART_TX_PARITY_EN)
package uart_pkg;

  localparam int UART_DATA_W               = 8;
  localparam int UART_STOP_BITS            = 1;
  localparam int UART_CLKS_PER_BIT_DEFAULT = 5208;

  // Serializer FSM states; the PARITY encoding is absent in the 8N1 build
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    ST_PARITY = 3'd3,
`endif
    ST_STOP   = 3'd4
  } uart_state_e;

  // Ceiling log2, evaluated at elaboration for counter widths
  function automatic int uart_clog2(input int value);
    int result;
    int v;
    result = 0;
    v      = value - 1;
    while (v > 0) begin
      result = result + 1;
      v      = v >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/uart_tx_serializer.sv
// rtl/uart_tx_serializer.sv - frame serializer: start, 8 data bits LSB first, optional even parity (UART_TX_PARITY_EN), stop
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT_DEFAULT
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   load_i,
  input  logic [UART_DATA_W-1:0] data_i,
  output logic                   busy_o,
  output logic                   txd_o
);

  localparam int                BAUD_W    = uart_clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]        BIT_LAST  = 3'(UART_DATA_W - 1);
  localparam logic [2:0]        STOP_LAST = 3'(UART_STOP_BITS - 1);

  uart_state_e            state_q;
  logic [BAUD_W-1:0]      baud_q;
  logic [2:0]             bit_q;
  logic [UART_DATA_W-1:0] shift_q;
  logic                   txd_q;
  logic                   busy_q;
  logic                   baud_done;
`ifdef UART_TX_PARITY_EN
  logic                   parity_q;
`endif

  assign baud_done = (baud_q == BAUD_LAST);
  assign txd_o     = txd_q;
  assign busy_o    = busy_q;

  // Frame FSM; the line level is registered so it changes only on state/bit boundaries
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      txd_q    <= 1'b1;
      busy_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (load_i) begin
            state_q  <= ST_START;
            shift_q  <= data_i;
            baud_q   <= '0;
            bit_q    <= '0;
            txd_q    <= 1'b0;
            busy_q   <= 1'b1;
`ifdef UART_TX_PARITY_EN
            parity_q <= ^data_i;
`endif
          end
        end

        ST_START: begin
          if (baud_done) begin
            baud_q  <= '0;
            bit_q   <= '0;
            state_q <= ST_DATA;
            txd_q   <= shift_q[0];
            shift_q <= shift_q >> 1;
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end

        ST_DATA: begin
          if (baud_done) begin
            baud_q <= '0;
            if (bit_q == BIT_LAST) begin
              bit_q   <= '0;
`ifdef UART_TX_PARITY_EN
              state_q <= ST_PARITY;
              txd_q   <= parity_q;
`else
              state_q <= ST_STOP;
              txd_q   <= 1'b1;
`endif
            end else begin
              bit_q   <= bit_q + 1'b1;
              txd_q   <= shift_q[0];
              shift_q <= shift_q >> 1;
            end
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end

`ifdef UART_TX_PARITY_EN
        ST_PARITY: begin
          if (baud_done) begin
            baud_q  <= '0;
            bit_q   <= '0;
            state_q <= ST_STOP;
            txd_q   <= 1'b1;
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
`endif

        ST_STOP: begin
          if (baud_done) begin
            baud_q <= '0;
            if (bit_q == STOP_LAST) begin
              bit_q   <= '0;
              state_q <= ST_IDLE;
              busy_q  <= 1'b0;
            end else begin
              bit_q <= bit_q + 1'b1;
            end
            txd_q <= 1'b1;
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end

        default: begin
          state_q <= ST_IDLE;
          baud_q  <= '0;
          bit_q   <= '0;
          txd_q   <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin arbiter sharing one UART transmitter among NUM_REQ byte producers (parity via UART_TX_PARITY_EN)
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT_DEFAULT,
  parameter int REQ_ID_W     = 2
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [NUM_REQ-1:0]             req_valid_i,
  input  logic [UART_DATA_W*NUM_REQ-1:0] req_data_i,
  output logic [NUM_REQ-1:0]             req_ready_o,
  output logic [REQ_ID_W-1:0]            grant_id_o,
  output logic                           busy_o,
  output logic                           TXD_o
);

  logic [REQ_ID_W-1:0]    ptr_q, ptr_d;
  logic [REQ_ID_W-1:0]    grant_q, grant_d;
  logic [REQ_ID_W-1:0]    win_id;
  logic [NUM_REQ-1:0]     win_oh;
  logic [UART_DATA_W-1:0] win_byte;
  logic                   win_vld;
  logic                   load;
  logic                   busy;
  int                     cand;

  // Winner search: visit requesters in order of distance from the pointer, wrapping at NUM_REQ
  always_comb begin
    win_vld  = 1'b0;
    win_id   = '0;
    win_oh   = '0;
    win_byte = '0;
    cand     = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = int'(ptr_q) + k;
      if (cand >= NUM_REQ) begin
        cand = cand - NUM_REQ;
      end
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!win_vld && (cand == i) && req_valid_i[i]) begin
          win_vld   = 1'b1;
          win_id    = REQ_ID_W'(i);
          win_oh[i] = 1'b1;
          win_byte  = req_data_i[i*UART_DATA_W +: UART_DATA_W];
        end
      end
    end
  end

  // The serializer is idle exactly when busy is low, so ready is a pure IDLE-cycle strobe
  assign load        = win_vld & ~busy;
  assign req_ready_o = busy ? '0 : win_oh;

  // Next pointer skips past the winner; grant id tracks the frame on the line and holds while idle
  always_comb begin
    ptr_d   = ptr_q;
    grant_d = grant_q;
    if (load) begin
      grant_d = win_id;
      ptr_d   = (int'(win_id) == NUM_REQ - 1) ? '0 : win_id + 1'b1;
    end
  end

  // Arbitration state registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ptr_q   <= '0;
      grant_q <= '0;
    end else begin
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
    end
  end

  assign grant_id_o = grant_q;
  assign busy_o     = busy;

  uart_tx_serializer #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_serializer (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .load_i (load),
    .data_i (win_byte),
    .busy_o (busy),
    .txd_o  (TXD_o)
  );

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - directed plus randomized bench for uart_tx_arbiter against a frame-level model (UART_TX_PARITY_EN aware)
module tb_uart_tx_arbiter;

  localparam int N   = 4;
  localparam int CPB = 10;
  localparam int IDW = 2;
`ifdef UART_TX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [8*N-1:0] req_data;
  logic [N-1:0]   req_ready;
  logic [IDW-1:0] grant_id;
  logic           busy;
  logic           txd;

  int n_checks = 0;
  int n_errors = 0;
  int mptr;
  bit rand_mode;
  int wd_req;
  int w;

  uart_tx_arbiter #(
    .NUM_REQ      (N),
    .CLKS_PER_BIT (CPB),
    .REQ_ID_W     (IDW)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .req_valid_i (req_valid),
    .req_data_i  (req_data),
    .req_ready_o (req_ready),
    .grant_id_o  (grant_id),
    .busy_o      (busy),
    .TXD_o       (txd)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Line level of frame bit idx: start, data LSB first, optional even parity, stop
  function automatic logic exp_bit(input logic [7:0] b, input int idx);
    if (idx == 0) return 1'b0;
    if (idx <= 8) return b[idx-1];
    if (idx == 9 && FRAME_BITS == 11) return ^b;
    return 1'b1;
  endfunction

  // Round-robin rule: first valid requester at or after the pointer, wrapping
  function automatic int model_winner(input logic [N-1:0] v, input int ptr);
    for (int k = 0; k < N; k++) begin
      if (v[(ptr + k) % N]) return (ptr + k) % N;
    end
    return -1;
  endfunction

  // Random producer activity that respects the hold-until-ready rule
  task automatic perturb;
    int j;
    j = $urandom_range(N - 1);
    if (!req_valid[j]) begin
      req_data[8*j +: 8] = 8'($urandom);
      req_valid[j]       = 1'b1;
    end else if ($urandom_range(2) == 0) begin
      req_valid[j] = 1'b0;
    end
  endtask

  // Called in an IDLE cycle: check the grant, then the whole frame on the line
  task automatic run_frame(input int id, input logic [7:0] b, input bit keep);
    #1;
    check_eq("ready_onehot", 32'(req_ready), 32'(1 << id));
    tick;
    if (!keep) req_valid[id] = 1'b0;
    check_eq("grant_id", 32'(grant_id), 32'(id));
    check_eq("busy_start", 32'(busy), 32'(1));
    check_eq("ready_after_capture", 32'(req_ready), 32'(0));
    for (int bi = 0; bi < FRAME_BITS; bi++) begin
      for (int c = 0; c < CPB; c++) begin
        if (c == 0 || c == CPB - 1)
          check_eq($sformatf("txd_id%0d_bit%0d_c%0d", id, bi, c), 32'(txd), 32'(exp_bit(b, bi)));
        if (c == CPB - 1 && bi == FRAME_BITS - 1)
          check_eq("busy_last_cycle", 32'(busy), 32'(1));
        if (c == 0) begin
          check_eq("ready_in_frame", 32'(req_ready), 32'(0));
          if (rand_mode && $urandom_range(3) == 0) perturb();
          if (wd_req >= 0 && bi == 2) begin
            req_data[8*wd_req +: 8] = 8'hE7;
            req_valid[wd_req]       = 1'b1;
          end
          if (wd_req >= 0 && bi == FRAME_BITS - 1) req_valid[wd_req] = 1'b0;
        end
        tick;
      end
    end
    check_eq("busy_end", 32'(busy), 32'(0));
    check_eq("txd_idle_end", 32'(txd), 32'(1));
    mptr = (id + 1) % N;
  endtask

  initial begin
    req_valid = '0;
    req_data  = '0;
    rst       = 1'b1;
    rand_mode = 1'b0;
    wd_req    = -1;
    mptr      = 0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_txd", 32'(txd), 32'(1));
    check_eq("rst_busy", 32'(busy), 32'(0));
    check_eq("rst_grant", 32'(grant_id), 32'(0));
    check_eq("rst_ready", 32'(req_ready), 32'(0));
    rst = 1'b0;
    tick;

    // Single request from requester 2, byte 0x41
    req_valid[2]     = 1'b1;
    req_data[16 +: 8] = 8'h41;
    run_frame(2, 8'h41, 1'b0);

    // Pointer wrap: 3 granted, then 1 and 3 compete; 1 wins first
    req_valid[3]      = 1'b1;
    req_data[24 +: 8] = 8'h5A;
    run_frame(3, 8'h5A, 1'b0);
    req_valid[1]      = 1'b1;
    req_data[8 +: 8]  = 8'h66;
    req_valid[3]      = 1'b1;
    req_data[24 +: 8] = 8'h99;
    run_frame(1, 8'h66, 1'b0);
    run_frame(3, 8'h99, 1'b0);

    // Requester 1 appears mid-frame and withdraws before IDLE: nothing further is sent
    req_valid[0]     = 1'b1;
    req_data[0 +: 8] = 8'h3C;
    wd_req = 1;
    run_frame(0, 8'h3C, 1'b0);
    wd_req = -1;
    #1;
    check_eq("withdrawn_ready", 32'(req_ready), 32'(0));
    for (int i = 0; i < 3; i++) begin
      tick;
      check_eq("withdrawn_busy", 32'(busy), 32'(0));
      check_eq("withdrawn_txd", 32'(txd), 32'(1));
    end

    // Byte with odd popcount exercises the parity bit when enabled
    req_valid[2]      = 1'b1;
    req_data[16 +: 8] = 8'h07;
    run_frame(2, 8'h07, 1'b0);

    // Reset during data bit 4; the pointer (3 before reset) must restart at 0
    req_valid[2]      = 1'b1;
    req_data[16 +: 8] = 8'h0F;
    #1;
    check_eq("rstmid_ready", 32'(req_ready), 32'(4));
    tick;
    req_valid[2] = 1'b0;
    repeat (5 * CPB + 3) tick;
    check_eq("rstmid_pre_txd", 32'(txd), 32'(0));
    check_eq("rstmid_pre_grant", 32'(grant_id), 32'(2));
    #2;
    rst = 1'b1;
    #1;
    check_eq("rstmid_txd", 32'(txd), 32'(1));
    check_eq("rstmid_busy", 32'(busy), 32'(0));
    check_eq("rstmid_grant", 32'(grant_id), 32'(0));
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    mptr = 0;
    req_valid[0]      = 1'b1;
    req_data[0 +: 8]  = 8'hA5;
    req_valid[3]      = 1'b1;
    req_data[24 +: 8] = 8'hC3;
    run_frame(0, 8'hA5, 1'b0);
    run_frame(3, 8'hC3, 1'b0);

    // All four continuously valid: grants rotate 0,1,2,3,0
    req_valid = '1;
    req_data  = {8'h43, 8'h32, 8'h21, 8'h10};
    run_frame(0, 8'h10, 1'b1);
    run_frame(1, 8'h21, 1'b1);
    run_frame(2, 8'h32, 1'b1);
    run_frame(3, 8'h43, 1'b1);
    run_frame(0, 8'h10, 1'b1);
    req_valid = '0;

    // Randomized producers checked against the round-robin model
    rand_mode = 1'b1;
    for (int f = 0; f < 60; f++) begin
      if ($urandom_range(1) == 1) perturb();
      if ($urandom_range(1) == 1) perturb();
      w = model_winner(req_valid, mptr);
      if (w < 0) begin
        #1;
        check_eq("rand_ready_none", 32'(req_ready), 32'(0));
        tick;
        check_eq("rand_idle_busy", 32'(busy), 32'(0));
        check_eq("rand_idle_txd", 32'(txd), 32'(1));
      end else begin
        run_frame(w, req_data[8*w +: 8], 1'b0);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one UART serial transmitter among NUM_REQ byte producers, e.g. an echo path, a status reporter and a debug dumper.
- Round-robin arbitration grants one requester per frame through a valid/ready handshake.
- Serializes the captured byte as 8N1 on TXD_o, with an optional parity bit.
- Sits between the design's byte sources and the board TXD pin.

Parameters:
- NUM_REQ, 4, number of requesters; range 2..8.
- CLKS_PER_BIT, 5208, clk_i cycles per bit (50 MHz / 9600 baud); minimum 2.
- REQ_ID_W, 2, width of grant_id_o; must be at least clog2(NUM_REQ).

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  asynchronous reset, active-high
- req_valid_i  in  NUM_REQ  per-requester byte valid
- req_data_i  in  8*NUM_REQ  byte of requester i at bits [8i+7:8i]
- req_ready_o  out  NUM_REQ  one-hot capture strobe; the byte transfers when valid & ready
- grant_id_o  out  REQ_ID_W  index of the requester whose frame is on the line
- busy_o  out  1  high from the cycle after capture until stop bit ends
- TXD_o  out  1  serial output; idle level 1

Behaviour:
- Reset (asynchronous, any state, including mid-frame):
  - TXD_o=1, busy_o=0, grant_id_o=0, req_ready_o=0.
  - State=IDLE, round-robin pointer=0, baud counter=0, bit counter=0.
  - An interrupted frame is abandoned and never resent.
- FSM states: IDLE, START, DATA, [PARITY], STOP.
- IDLE:
  - Winner = first requester with valid=1, scanning upward from pointer and wrapping NUM_REQ-1 to 0.
  - req_ready_o[winner] is combinational = (state==IDLE) & valid[winner]. Exactly one bit is high; all bits are 0 if no valid.
  - On that edge: shift reg <= winner's byte, grant_id_o <= winner, pointer <= (winner+1) mod NUM_REQ, go to START.
- START: TXD_o=0 for CLKS_PER_BIT cycles; baud counter counts 0..CLKS_PER_BIT-1.
- DATA: 8 bits, LSB (bit 0) first, each held CLKS_PER_BIT cycles; bit counter 0..7.
- STOP: TXD_o=1 for CLKS_PER_BIT cycles, then IDLE; busy_o drops on entry to IDLE.
- Latency: TXD_o falls on the cycle after the capture edge. TXD_o is registered, with no combinational path from inputs.
- Frame period: 10*CLKS_PER_BIT cycles (11 with parity). There is one mandatory IDLE cycle between back-to-back frames.
- Handshake rules:
  - A requester holds valid and data stable until it sees ready.
  - Deasserting valid before ready is legal; no transfer occurs.
  - valid asserted during a frame waits for the next IDLE.
- Fairness: with all requesters continuously valid, grants rotate 0,1,2,3,0,... No requester waits more than NUM_REQ-1 frames.
- Simultaneous events: valid arriving in the same cycle the FSM enters IDLE is evaluated in that IDLE cycle. Only one grant per IDLE cycle.
- Counter widths: baud counter is clog2(CLKS_PER_BIT) bits; bit counter is 3 bits; pointer is REQ_ID_W bits and wraps at NUM_REQ, not 2^REQ_ID_W.
- grant_id_o holds its last value while IDLE.

Optional Feature:
- Macro UART_TX_PARITY_EN.
- When defined: a PARITY state follows DATA, transmitting even parity (XOR of the 8 data bits) for CLKS_PER_BIT cycles before STOP. Frame becomes 8E1, 11*CLKS_PER_BIT cycles.
- When undefined: there is no PARITY state and the frame is 8N1. No parity logic or state encoding exists.

Decomposition:
- Shared package uart_pkg:
  - FSM state enum (IDLE, START, DATA, PARITY, STOP).
  - Constants UART_DATA_W=8, UART_STOP_BITS=1, and the default CLKS_PER_BIT.
  - A function computing clog2.
- Sub-module uart_tx_serializer:
  - Owns the baud counter, bit counter, shift register, parity and TXD_o.
  - Interface: load strobe + byte in, busy out.
- The top keeps the round-robin arbiter, the pointer, the ready generation and grant_id_o.

Test Plan (CLKS_PER_BIT=10, NUM_REQ=4):
- Single request: valid[2]=1, data[2]=0x41 → ready[2] high 1 cycle, grant_id_o=2. TXD_o low the next cycle for 10 cycles, then 1,0,0,0,0,0,1,0 each 10 cycles, then 1. busy_o low after 100 cycles.
- All four valid continuously with bytes 0x10/0x21/0x32/0x43 → grants in order 0,1,2,3,0. Each frame is 100 cycles plus 1 IDLE cycle. Each ready pulse aligns with its requester's byte.
- Pointer wrap: after requester 3 is granted, valid[1] and valid[3] → requester 1 wins, then requester 3.
- Reset mid-frame: rst_i pulse during DATA bit 4 → TXD_o=1 immediately, busy_o=0. Next grant goes to requester 0 if valid[0]=1 and valid[3]=1.
- Valid withdrawn: valid[1] asserted during a busy frame, then dropped before IDLE → no ready[1], TXD_o stays 1, no frame sent.
- Parity build (UART_TX_PARITY_EN) with byte 0x07 → parity bit 1 after bit 7. Frame is 110 cycles; stop bit follows.
